vga_sync_gen: RTL and testbench

- Timing master for the VGA output path; the pixel pattern blocks (win screens, board views) consume its counters.
- Divides the 100 MHz system clock to a 25 MHz pixel-enable tick and runs the 800x525 horizontal/vertical counters.
- Pattern blocks decode colour combinationally from the counters; this block registers that colour, blanks it outside the active window, and emits aligned active-low Hsync/Vsync.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/pixel_tick_gen.sv | 38 +++
 rtl/vga_sync_gen.sv | 114 +++++++++++
 tb/tb_vga_sync_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and types for the sync generator and
// the pattern blocks that decode colour from its counters.
package vga_timing_pkg;

  localparam int unsigned CntWidth = 10;

  localparam int unsigned DefHTotal    = 800;
  localparam int unsigned DefHSync     = 96;
  localparam int unsigned DefHActStart = 144;
  localparam int unsigned DefHActEnd   = 784;

  localparam int unsigned DefVTotal    = 525;
  localparam int unsigned DefVSync     = 2;
  localparam int unsigned DefVActStart = 35;
  localparam int unsigned DefVActEnd   = 515;

  typedef logic [3:0] colour_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clk pixel-enable pulse every CLK_DIV clocks;
// the first pulse lands in the CLK_DIV-th clock after reset release.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_pixel_tick
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] r_div;
  logic [DivW-1:0] w_div_next;
  logic            r_tick;

  always_comb begin
    w_div_next = r_div + 1'b1;
    if (r_div == DivLast) begin
      w_div_next = '0;
    end
  end

  // Registered tick tracks the divider value it will hold, so the pulse is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_tick <= (w_div_next == DivLast);
    end
  end

  assign o_pixel_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel-tick driven H/V counters plus a registered output stage that
// blanks pattern colour and emits active-low syncs one pixel tick behind the counters.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = DefHTotal,
  parameter int unsigned H_SYNC      = DefHSync,
  parameter int unsigned H_ACT_START = DefHActStart,
  parameter int unsigned H_ACT_END   = DefHActEnd,
  parameter int unsigned V_TOTAL     = DefVTotal,
  parameter int unsigned V_SYNC      = DefVSync,
  parameter int unsigned V_ACT_START = DefVActStart,
  parameter int unsigned V_ACT_END   = DefVActEnd
) (
  input  logic        clk,
  input  logic        rst_n,
  input  colour_t     Red_In,
  input  colour_t     Green_In,
  input  colour_t     Blue_In,
  output logic [15:0] H_Counter_Value,
  output logic [15:0] V_Counter_Value,
  output logic        pixel_tick,
  output logic        frame_start,
  output logic        video_on,
  output logic        Hsync,
  output logic        Vsync,
  output colour_t     Red,
  output colour_t     Green,
  output colour_t     Blue
);

  localparam logic [CntWidth-1:0] HLast     = CntWidth'(H_TOTAL - 1);
  localparam logic [CntWidth-1:0] VLast     = CntWidth'(V_TOTAL - 1);
  localparam logic [CntWidth-1:0] HSyncEnd  = CntWidth'(H_SYNC);
  localparam logic [CntWidth-1:0] VSyncEnd  = CntWidth'(V_SYNC);
  localparam logic [CntWidth-1:0] HActStart = CntWidth'(H_ACT_START);
  localparam logic [CntWidth-1:0] HActEnd   = CntWidth'(H_ACT_END);
  localparam logic [CntWidth-1:0] VActStart = CntWidth'(V_ACT_START);
  localparam logic [CntWidth-1:0] VActEnd   = CntWidth'(V_ACT_END);

  logic                w_tick;
  logic [CntWidth-1:0] r_h;
  logic [CntWidth-1:0] r_v;
  logic                w_h_last;
  logic                w_v_last;
  logic                w_act;

  logic    r_hsync;
  logic    r_vsync;
  logic    r_video_on;
  colour_t r_red;
  colour_t r_green;
  colour_t r_blue;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_pixel_tick(w_tick)
  );

  assign w_h_last = (r_h == HLast);
  assign w_v_last = (r_v == VLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign w_act = (r_h >= HActStart) && (r_h < HActEnd) &&
                 (r_v >= VActStart) && (r_v < VActEnd);

  // Output stage samples the counters as they stood during the tick, hence one tick of lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
      r_red      <= '0;
      r_green    <= '0;
      r_blue     <= '0;
    end else if (w_tick) begin
      r_hsync    <= !(r_h < HSyncEnd);
      r_vsync    <= !(r_v < VSyncEnd);
      r_video_on <= w_act;
      r_red      <= w_act ? Red_In   : '0;
      r_green    <= w_act ? Green_In : '0;
      r_blue     <= w_act ? Blue_In  : '0;
    end
  end

  assign H_Counter_Value = {{(16 - CntWidth){1'b0}}, r_h};
  assign V_Counter_Value = {{(16 - CntWidth){1'b0}}, r_v};
  assign pixel_tick      = w_tick;
  assign frame_start     = w_tick & w_h_last & w_v_last;
  assign video_on        = r_video_on;
  assign Hsync           = r_hsync;
  assign Vsync           = r_vsync;
  assign Red             = r_red;
  assign Green           = r_green;
  assign Blue            = r_blue;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full horizontal timing with a shortened frame, random colour
// stimulus checked every clock against an arithmetic model of pixel index vs clocks.
module tb_vga_sync_gen;

  localparam int unsigned D   = 4;
  localparam int unsigned HT  = 800;
  localparam int unsigned HS  = 96;
  localparam int unsigned HAS = 144;
  localparam int unsigned HAE = 784;
  localparam int unsigned VT  = 8;
  localparam int unsigned VS  = 2;
  localparam int unsigned VAS = 3;
  localparam int unsigned VAE = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  red_in = '0, green_in = '0, blue_in = '0;
  logic [15:0] h_cnt, v_cnt;
  logic        tick_o, fs_o, von_o, hs_o, vs_o;
  logic [3:0]  red_o, green_o, blue_o;

  vga_sync_gen #(
    .CLK_DIV    (D),
    .H_TOTAL    (HT),
    .H_SYNC     (HS),
    .H_ACT_START(HAS),
    .H_ACT_END  (HAE),
    .V_TOTAL    (VT),
    .V_SYNC     (VS),
    .V_ACT_START(VAS),
    .V_ACT_END  (VAE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Red_In         (red_in),
    .Green_In       (green_in),
    .Blue_In        (blue_in),
    .H_Counter_Value(h_cnt),
    .V_Counter_Value(v_cnt),
    .pixel_tick     (tick_o),
    .frame_start    (fs_o),
    .video_on       (von_o),
    .Hsync          (hs_o),
    .Vsync          (vs_o),
    .Red            (red_o),
    .Green          (green_o),
    .Blue           (blue_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Clock edges seen since reset release; everything expected is derived from this.
  int unsigned m = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 0;
    else        m <= m + 1;
  end

  logic [3:0]  cap_r = '0, cap_g = '0, cap_b = '0;
  int unsigned hs_low_cnt = 0, vs_low_cnt = 0, fs_cnt = 0;
  logic        align = 1'b0;
  int unsigned green_hits = 0, green_first = 0;

  always @(negedge clk) begin : cmp
    int unsigned p, h, v, q, qh, qv;
    logic        tk, fs, act, ehs, evs;
    logic [3:0]  er, eg, eb;
    p  = m / D;
    h  = p % HT;
    v  = (p / HT) % VT;
    tk = (m % D) == D - 1;
    fs = tk && ((p % (HT * VT)) == HT * VT - 1);
    if (m < D) begin
      ehs = 1'b1; evs = 1'b1; act = 1'b0;
    end else begin
      q   = p - 1;
      qh  = q % HT;
      qv  = (q / HT) % VT;
      ehs = qh >= HS;
      evs = qv >= VS;
      act = (qh >= HAS) && (qh < HAE) && (qv >= VAS) && (qv < VAE);
    end
    er = act ? cap_r : 4'h0;
    eg = act ? cap_g : 4'h0;
    eb = act ? cap_b : 4'h0;

    chk("h_count", 32'(h_cnt), h);
    chk("v_count", 32'(v_cnt), v);
    chk("pixel_tick", 32'(tick_o), 32'(tk));
    chk("frame_start", 32'(fs_o), 32'(fs));
    chk("hsync", 32'(hs_o), 32'(ehs));
    chk("vsync", 32'(vs_o), 32'(evs));
    chk("video_on", 32'(von_o), 32'(act));
    chk("rgb", 32'({red_o, green_o, blue_o}), 32'({er, eg, eb}));

    // Hand-computed anchors that pin the model itself.
    if (!rst_n) begin
      hs_low_cnt = 0; vs_low_cnt = 0; fs_cnt = 0;
    end else begin
      if (m < 3200 && hs_o == 1'b0) hs_low_cnt++;
      if (m < 25600 && vs_o == 1'b0) vs_low_cnt++;
      if (m < 25600 && fs_o == 1'b1) fs_cnt++;
      if (m == 2) chk("lit_no_tick_m2", 32'(tick_o), 0);
      if (m == 3) chk("lit_first_tick", 32'(tick_o), 1);
      if (m == 3) chk("lit_hsync_pre_tick", 32'(hs_o), 1);
      if (m == 4) chk("lit_h_after_tick", 32'(h_cnt), 1);
      if (m == 4) chk("lit_hsync_low", 32'(hs_o), 0);
      if (m == 4) chk("lit_vsync_low", 32'(vs_o), 0);
      if (m == 3199) chk("lit_hsync_low_clks", hs_low_cnt, 384);
      if (m == 3200) chk("lit_line_wrap_h", 32'(h_cnt), 0);
      if (m == 3200) chk("lit_line_wrap_v", 32'(v_cnt), 1);
      if (m == 25599) chk("lit_frame_start", 32'(fs_o), 1);
      if (m == 25599) chk("lit_frame_start_count", fs_cnt, 1);
      if (m == 25599) chk("lit_vsync_low_clks", vs_low_cnt, 6400);
    end
    if (align && green_o == 4'hF) begin
      if (green_hits == 0) green_first = m;
      green_hits++;
      chk("align_video_on", 32'(von_o), 1);
    end

    if (rst_n && tk) begin
      cap_r = red_in; cap_g = green_in; cap_b = blue_in;
    end
  end

  initial begin : stim
    int unsigned p, h, v;
    #23 rst_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      p = m / D;
      h = p % HT;
      v = (p / HT) % VT;
      if (m >= 25600) align = 1'b1;
      if (align && h == 500 && v == 5 && (m % D) == 1) break;
      if (align) begin
        red_in   = 4'h0;
        blue_in  = 4'h0;
        green_in = (h == 200 && v == 4) ? 4'hF : 4'h0;
      end else begin
        {red_in, green_in, blue_in} = 12'($urandom);
      end
    end

    chk("pre_reset_video_on", 32'(von_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_h", 32'(h_cnt), 0);
    chk("async_rst_v", 32'(v_cnt), 0);
    chk("async_rst_video_on", 32'(von_o), 0);
    chk("async_rst_sync", 32'({hs_o, vs_o}), 3);
    chk("async_rst_rgb", 32'({red_o, green_o, blue_o}), 0);
    chk("async_rst_pulses", 32'({tick_o, fs_o}), 0);
    chk("align_green_clks", green_hits, D);
    chk("align_green_first", green_first, 39204);
    align = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    repeat (7000) begin
      @(posedge clk);
      #1;
      {red_in, green_in, blue_in} = 12'($urandom);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
